// File: rtl/dffe_pipe_pkg.sv
// Shared defaults and sizing helpers for the elastic register pipeline.
package dffe_pipe_pkg;

    localparam int DEF_W = 32;
    localparam int DEF_D = 4;

    // Occupancy counts 0..d inclusive, so it needs one more code than d.
    function automatic int occ_width(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/dffe_pipe_if.sv
// Valid/ready handshake bundle for both ends of the pipeline.
interface dffe_pipe_if
    import dffe_pipe_pkg::*;
#(
    parameter int W = DEF_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dffe_pipe_stage.sv
// One pipeline slot: a valid bit plus payload register with load, flush and reset.
module dffe_pipe_stage
    import dffe_pipe_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         load_i,
    input  logic         src_valid_i,
    input  logic [W-1:0] src_data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next state: the payload only moves when the source actually carries an item.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = src_valid_i;
            if (src_valid_i) begin
                data_d = src_data_i;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/dffe_pipe.sv
// Elastic D-stage register pipeline with bubble collapse, flush and occupancy count.
module dffe_pipe
    import dffe_pipe_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int D = DEF_D,
    localparam int OW = occ_width(D)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    dffe_pipe_if.slave    bus,
    output logic [OW-1:0] occupancy
);

    localparam logic [OW-1:0] OCC_ONE = OW'(1'b1);

    logic [D:0]    rdy_s;
    logic [D-1:0]  valid_s;
    logic [W-1:0]  data_s [D];
    logic          push_s;
    logic          pop_s;
    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;

    // Ready ripples back from the sink; an empty slot is always ready, which collapses bubbles.
    always_comb begin
        rdy_s    = {(D + 1){1'b0}};
        rdy_s[D] = bus.out_ready;
        for (int i = D - 1; i >= 0; i--) begin
            rdy_s[i] = !valid_s[i] || rdy_s[i + 1];
        end
    end

    for (genvar i = 0; i < D; i++) begin : g_stage
        logic         src_valid_s;
        logic [W-1:0] src_data_s;

        if (i == 0) begin : g_head
            assign src_valid_s = bus.in_valid;
            assign src_data_s  = bus.in_data;
        end else begin : g_body
            assign src_valid_s = valid_s[i-1];
            assign src_data_s  = data_s[i-1];
        end

        dffe_pipe_stage #(.W(W)) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush_i     (flush),
            .load_i      (rdy_s[i]),
            .src_valid_i (src_valid_s),
            .src_data_i  (src_data_s),
            .valid_o     (valid_s[i]),
            .data_o      (data_s[i])
        );
    end

    assign bus.in_ready  = rdy_s[0] && !flush && rst_n;
    assign bus.out_valid = valid_s[D-1];
    assign bus.out_data  = data_s[D-1];

    assign push_s = bus.in_valid && bus.in_ready;
    assign pop_s  = valid_s[D-1] && bus.out_ready;

    // Occupancy tracks pushes minus pops, which equals the number of set valid bits.
    always_comb begin
        occ_d = occ_q;
        if (push_s && !pop_s) begin
            occ_d = occ_q + OCC_ONE;
        end else if (pop_s && !push_s) begin
            occ_d = occ_q - OCC_ONE;
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy register; flush empties every slot at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q <= {OW{1'b0}};
        end else if (flush) begin
            occ_q <= {OW{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: doc/dffe_pipe.md
DFFE_PIPE -- requirements
Module: dffe_pipe

Interface
REQ-001 SHALL have parameter W, default 32, meaning payload width in bits (W >= 1).
REQ-002 SHALL have parameter D, default 4, meaning number of register stages (D >= 1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, which discards all held data.
REQ-006 SHALL have port in_valid, input, 1, meaning the upstream offers in_data.
REQ-007 SHALL have port in_ready, output, 1, meaning stage 0 can accept this cycle.
REQ-008 SHALL have port in_data, input, W, the upstream payload.
REQ-009 SHALL have port out_valid, output, 1, meaning the last stage holds valid data.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream accepts this cycle.
REQ-011 SHALL have port out_data, output, W, the last-stage payload.
REQ-012 SHALL have port occupancy, output, $clog2(D+1), giving the count of valid stages.

Function
REQ-013 SHALL hold a valid bit v[i] and a data register d[i] for each stage i = 0..D-1; stage D-1 drives out_valid and out_data.
REQ-014 SHALL define rdy[D] = out_ready and rdy[i] = !v[i] || rdy[i+1]; in_ready = rdy[0] && !flush && rst_n.
REQ-015 SHALL load stage i when rdy[i] is high: v[i] <= v[i-1] (or in_valid for i=0), and d[i] <= d[i-1] (or in_data) only if the source is valid.
REQ-016 SHALL hold stage i (v and d unchanged) when rdy[i] is low.
REQ-017 SHALL collapse bubbles: an empty stage accepts from upstream even when downstream is stalled.
REQ-018 SHALL give a latency of exactly D cycles from in_valid&&in_ready to out_valid with no stall, at a sustained throughput of one item per cycle.
REQ-019 SHALL keep out_data stable and out_valid high while out_valid && !out_ready; out_valid drops only after a handshake, flush, or reset.
REQ-020 SHALL accept a new input in the same cycle as an output handshake when full (all v=1, out_ready=1).
REQ-021 SHALL clear all v[i] on the next edge when flush=1 and accept no input that cycle; a flush has priority over any handshake, and out_data is don't-care afterward.
REQ-022 SHALL update occupancy registered, equal to popcount(v) after each edge, ranging 0..D.
REQ-023 SHALL preserve item order; no item is duplicated or dropped except by flush or reset.
REQ-024 SHALL behave for D=1 as a single registered stage with in_ready = !v[0] || out_ready.

Reset
REQ-025 SHALL clear all v[i], all d[i] to 0, and occupancy to 0 on a clock edge with rst_n=0.
REQ-026 SHALL hold in_ready=0, out_valid=0, and out_data=0 while rst_n=0, with inputs ignored.
REQ-027 SHALL discard in-flight items when reset is asserted mid-stream, and resume accepting on the first edge after rst_n returns to 1.

Structure
REQ-028 SHALL place the default W and D values and the occupancy-width localparam function in shared package dffe_pipe_pkg.
REQ-029 SHALL implement one stage (valid bit plus W-bit data register with load/flush/reset) as sub-module dffe_pipe_stage, instantiated D times by generate.
REQ-030 SHALL keep the ready chain purely combinational and contain no other combinational path from input to output data.

Verification
REQ-031 SHALL be checked for streaming: with W=8, D=4, out_ready=1, and in_data 0x01..0x08 on consecutive cycles, out_data shows 0x01..0x08 starting 4 cycles later, one item per cycle.
REQ-032 SHALL be checked for stall/fill: with out_ready=0 and 6 offers, 4 are accepted, then in_ready=0 and occupancy=4; out_data=0x01 stays stable until out_ready=1, and order is preserved.
REQ-033 SHALL be checked for bubble collapse: with items 0xA1, gap, 0xA2 and out_ready=0, the result is occupancy=2 with stages D-1 and D-2 holding 0xA1 and 0xA2.
REQ-034 SHALL be checked for simultaneous events: when full with out_ready=1 and in_valid=1, one item leaves and one enters per cycle and occupancy stays 4.
REQ-035 SHALL be checked for flush and reset: flush with occupancy=3 gives occupancy=0 and out_valid=0 next cycle with the concurrent input dropped; rst_n=0 mid-stream gives all outputs 0 and the first post-reset item emerges after D cycles.
